// File: rtl/post_spike_aer_encoder.sv
// rtl/post_spike_aer_encoder.sv - serializes post-neuron spike vectors into AER events through a FWFT FIFO
// Optional time-step marker events: define AER_TSTEP_MARKER_EN.
module post_spike_aer_encoder #(
   parameter int POST_NEUR_PARALLEL        = 4,
   parameter int POST_NEUR_WORD_ADDR_WIDTH = 8,
   parameter int POST_NEUR_BYTE_ADDR_WIDTH = 2,
   parameter int AER_WIDTH                 = 12,
   parameter int FIFO_DEPTH                = 16
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 spk_valid,
   output logic                                 spk_ready,
   input  logic [POST_NEUR_PARALLEL-1:0]        spk_vec,
   input  logic [POST_NEUR_WORD_ADDR_WIDTH-1:0] spk_word_addr,
   input  logic                                 tstep_event,
   input  logic                                 cnt_clr,
   output logic                                 aer_valid,
   input  logic                                 aer_ready,
   output logic [AER_WIDTH-1:0]                 aer_addr,
   output logic [$clog2(FIFO_DEPTH):0]          fifo_level,
   output logic [15:0]                          spike_total
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;
   localparam int EW = POST_NEUR_WORD_ADDR_WIDTH + POST_NEUR_BYTE_ADDR_WIDTH;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                                 state_q, state_d;
   logic [POST_NEUR_PARALLEL-1:0]          vec_q, vec_d, lane_mask;
   logic [POST_NEUR_WORD_ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [POST_NEUR_BYTE_ADDR_WIDTH-1:0]   lane;
   logic [AER_WIDTH-1:0]                   spike_addr, push_data;
   logic [AER_WIDTH-1:0]                   mem [FIFO_DEPTH];
   logic [PW-1:0]                          wr_ptr, rd_ptr;
   logic [LW-1:0]                          count;
   logic [15:0]                            spike_cnt;
   logic                                   full, empty, push, pop;
   logic                                   spike_push, marker_push, marker_pend;

   assign full  = (count == LW'(FIFO_DEPTH));
   assign empty = (count == '0);
   assign pop   = !empty && aer_ready;

   // Isolate the lowest set lane; the loop runs downward so the lowest index wins.
   assign lane_mask = vec_q & (~vec_q + 1'b1);
   always_comb begin
      lane = '0;
      for (int i = POST_NEUR_PARALLEL - 1; i >= 0; i--) begin
         if (vec_q[i]) lane = POST_NEUR_BYTE_ADDR_WIDTH'(i);
      end
   end

   always_comb begin
      spike_addr         = '0;
      spike_addr[EW-1:0] = {addr_q, lane};
   end

`ifdef AER_TSTEP_MARKER_EN
   // A marker waits for the serializer to go idle, then takes priority over new captures.
   assign marker_push = (state_q == IDLE) && marker_pend && !full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         marker_pend <= 1'b0;
      else if (marker_push)
         marker_pend <= 1'b0;
      else if (tstep_event)
         marker_pend <= 1'b1;
   end
`else
   logic unused_tstep;
   assign unused_tstep = tstep_event;
   assign marker_pend  = 1'b0;
   assign marker_push  = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         vec_q   <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         addr_q  <= addr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      vec_d      = vec_q;
      addr_d     = addr_q;
      spike_push = 1'b0;
      spk_ready  = rst_n && (state_q == IDLE) && !marker_pend;
      case (state_q)
         IDLE: begin
            if (spk_valid && spk_ready) begin
               vec_d  = spk_vec;
               addr_d = spk_word_addr;
               if (spk_vec != '0) state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (!full) begin
               spike_push = 1'b1;
               vec_d      = vec_q & ~lane_mask;
               if (vec_d == '0) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign push      = spike_push || marker_push;
   assign push_data = marker_push ? '1 : spike_addr;

   // Fullness is judged on the registered count, so a same-cycle pop never frees a slot early.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + LW'(push) - LW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         spike_cnt <= '0;
      else if (cnt_clr)
         spike_cnt <= '0;
      else if (spike_push && spike_cnt != 16'hFFFF)
         spike_cnt <= spike_cnt + 16'd1;
   end

   assign aer_valid   = !empty;
   assign aer_addr    = empty ? '0 : mem[rd_ptr];
   assign fifo_level  = count;
   assign spike_total = spike_cnt;

endmodule

// File: doc/post_spike_aer_encoder.md
POST_SPIKE_AER_ENCODER -- requirements
Module: post_spike_aer_encoder

Interface
REQ-001 SHALL have parameter POST_NEUR_PARALLEL, default 4, lanes per post-neuron SRAM word.
REQ-002 SHALL have parameter POST_NEUR_WORD_ADDR_WIDTH, default 8, post-neuron word address width.
REQ-003 SHALL have parameter POST_NEUR_BYTE_ADDR_WIDTH, default 2, lane index width (log2 of POST_NEUR_PARALLEL).
REQ-004 SHALL have parameter AER_WIDTH, default 12, output event address width (>= word+byte widths).
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, output FIFO entries (power of two).
REQ-006 SHALL have ports: CLK  input  1  clock; all logic on rising edge.
REQ-007 RST_N  input  1  reset, asynchronous, active-low.
REQ-008 SPK_VALID  input  1  spike vector valid from neuron core update.
REQ-009 SPK_READY  output  1  encoder can accept a vector.
REQ-010 SPK_VEC  input  POST_NEUR_PARALLEL  per-lane spike flags (neuron core event outputs).
REQ-011 SPK_WORD_ADDR  input  POST_NEUR_WORD_ADDR_WIDTH  post-neuron word address of SPK_VEC.
REQ-012 TSTEP_EVENT  input  1  single-cycle time-step boundary pulse.
REQ-013 CNT_CLR  input  1  synchronous clear of SPIKE_TOTAL.
REQ-014 AER_VALID  output  1  AER_ADDR holds a valid event.
REQ-015 AER_READY  input  1  consumer accepts event.
REQ-016 AER_ADDR  output  AER_WIDTH  event address.
REQ-017 FIFO_LEVEL  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-018 SPIKE_TOTAL  output  16  count of spike events pushed into FIFO.

Function
REQ-019 Serializer SHALL have states IDLE and SHIFT; SPK_READY=1 only in IDLE with no marker pending.
REQ-020 In IDLE, SPK_VALID&&SPK_READY SHALL capture SPK_VEC and SPK_WORD_ADDR; nonzero vector -> SHIFT next cycle, zero vector -> stay IDLE, nothing pushed.
REQ-021 In SHIFT, each cycle FIFO is not full, SHALL push lowest-index set lane and clear that bit; last bit cleared -> IDLE.
REQ-022 Event address SHALL be {SPK_WORD_ADDR, lane} zero-extended in MSBs to AER_WIDTH.
REQ-023 FIFO full SHALL stall the serializer with no loss; a pop in the same cycle SHALL NOT permit a push that cycle.
REQ-024 FIFO SHALL be first-word-fall-through: AER_VALID = not empty; AER_ADDR = head entry; pop on AER_VALID&&AER_READY.
REQ-025 Latency: vector captured at edge k -> first event AER_VALID after edge k+1 (FIFO empty); one event per cycle thereafter.
REQ-026 Events SHALL leave in push order; AER_ADDR/AER_VALID SHALL be stable while AER_VALID&&!AER_READY.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH; FIFO_LEVEL SHALL range 0..FIFO_DEPTH.
REQ-028 SPIKE_TOTAL SHALL increment per spike push, saturate at 16'hFFFF; CNT_CLR SHALL zero it with priority over increment.

Reset
REQ-029 RST_N low SHALL force IDLE, empty FIFO, pointers 0, marker flag 0, SPIKE_TOTAL 0, capture registers 0.
REQ-030 During reset outputs SHALL be: SPK_READY=0, AER_VALID=0, AER_ADDR=0, FIFO_LEVEL=0, SPIKE_TOTAL=0; SPK_READY=1 first cycle after release.
REQ-031 Reset mid-SHIFT or with non-empty FIFO SHALL discard all pending events.

Configuration
REQ-032 Macro AER_TSTEP_MARKER_EN defined: TSTEP_EVENT SHALL set a pending marker flag; marker (AER_ADDR all ones) SHALL be pushed when serializer in IDLE and FIFO not full, ahead of any new capture; marker excluded from SPIKE_TOTAL.
REQ-033 TSTEP_EVENT during SHIFT SHALL push the marker only after the current vector completes; a second TSTEP_EVENT while pending SHALL NOT queue a second marker.
REQ-034 Macro undefined: TSTEP_EVENT SHALL be ignored; no marker logic; port retained.

Verification
REQ-035 SPK_VEC=4'b1011, WORD_ADDR=8'h05, AER_READY=1 -> AER_ADDR 0x014,0x015,0x017 on consecutive cycles; SPIKE_TOTAL=3.
REQ-036 SPK_VEC=4'b0000 -> no AER_VALID, SPK_READY high next cycle, SPIKE_TOTAL unchanged.
REQ-037 AER_READY=0, five vectors of 4'b1111 -> FIFO_LEVEL=16, serializer stalls in SHIFT, SPK_READY=0; release AER_READY -> all 20 events out in order, none lost.
REQ-038 With AER_TSTEP_MARKER_EN, TSTEP_EVENT during SHIFT of 4'b0110 -> two spike events then 0xFFF; SPIKE_TOTAL=2.
REQ-039 RST_N asserted mid-SHIFT with FIFO_LEVEL=3 -> AER_VALID=0, FIFO_LEVEL=0 immediately; SPK_READY=1 first cycle after release.
REQ-040 SPIKE_TOTAL preset to 16'hFFFE, vector 4'b0111 -> saturates at 16'hFFFF; CNT_CLR with simultaneous push -> 0.
